// File: rtl/bp_train_ctrl_pkg.sv
// Shared definitions for the backprop mini-batch training sequencer:
// FSM state encoding and the bit positions of the bp control pulses.
package bp_train_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_WAIT = 3'd3,
    ST_ACCU = 3'd4,
    ST_UPD  = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  localparam int PULSE_W    = 5;
  localparam int P_LD       = 0;
  localparam int P_ACCU     = 1;
  localparam int P_RST_BTCH = 2;
  localparam int P_WB_UPD   = 3;
  localparam int P_DONE     = 4;

  typedef logic [PULSE_W-1:0] pulse_t;

  // Each state owns at most one pulse, so the pulses are exclusive by construction.
  function automatic pulse_t pulse_for(input state_t s);
    pulse_t p;
    p = '0;
    case (s)
      ST_LOAD: p[P_LD]       = 1'b1;
      ST_ACCU: p[P_ACCU]     = 1'b1;
      ST_CLR:  p[P_RST_BTCH] = 1'b1;
      ST_UPD:  p[P_WB_UPD]   = 1'b1;
      ST_DONE: p[P_DONE]     = 1'b1;
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/bp_train_ctrl_ctrl_cnt.sv
// Loadable down-counter with a zero flag; saturates at zero.
module ctrl_cnt
  import bp_train_ctrl_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bp_train_ctrl.sv
// Mini-batch training sequencer: walks the sample memory, waits the forward
// latency, pulses bp accumulate, and commits deltas at each batch boundary.
module bp_train_ctrl
  import bp_train_ctrl_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BATCH  = 4,
  parameter int FF_LAT = 3,
  parameter int SMP_AW = 8,
  parameter int EP_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [SMP_AW:0]   i_n_smp,
  input  logic [EP_W-1:0]   i_n_epoch,
  input  logic [WIDTH-1:0]  i_cost,
  output logic [SMP_AW-1:0] o_smp_addr,
  output logic              o_ld,
  output logic              o_accu,
  output logic              o_rst_btch,
  output logic              o_wb_upd,
  output logic [WIDTH-1:0]  o_cost,
  output logic [EP_W-1:0]   o_epoch,
  output logic              o_busy,
  output logic              o_done
);

  // Both counters hold "remaining minus one" so the zero flag marks the last cycle/sample.
  localparam int WAIT_W = (FF_LAT > 1) ? $clog2(FF_LAT) : 1;
  localparam int BTCH_W = (BATCH > 1) ? $clog2(BATCH) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(FF_LAT - 1);
  localparam logic [BTCH_W-1:0] BTCH_INIT = BTCH_W'(BATCH - 1);

  state_t          state, next_state;
  pulse_t          pulse_d, pulse_q;
  logic            busy_d;
  logic [SMP_AW:0] n_smp, addr, addr_nxt;
  logic [EP_W-1:0] n_epoch, epoch;
  logic            wait_zero, btch_zero;
  logic            addr_last, addr_in_range, epoch_last;

  assign addr_last     = ((addr + (SMP_AW+1)'(1)) == n_smp);
  assign addr_in_range = (addr < n_smp);
  assign epoch_last    = (({1'b0, epoch} + (EP_W+1)'(1)) == {1'b0, n_epoch});
  assign addr_nxt      = (state == ST_ACCU) ? addr + (SMP_AW+1)'(1) : addr;

  ctrl_cnt #(.W(WAIT_W)) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_LOAD),
    .load_val (WAIT_INIT),
    .dec      (state == ST_WAIT),
    .zero     (wait_zero)
  );

  ctrl_cnt #(.W(BTCH_W)) u_btch_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_CLR),
    .load_val (BTCH_INIT),
    .dec      (state == ST_ACCU),
    .zero     (btch_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      pulse_q <= '0;
      o_busy  <= 1'b0;
    end else begin
      state   <= next_state;
      pulse_q <= pulse_d;
      o_busy  <= busy_d;
    end
  end

  always_comb begin
    next_state = state;
    if (i_abort) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (i_start)
                   next_state = ((i_n_smp != '0) && (i_n_epoch != '0)) ? ST_CLR : ST_DONE;
        ST_CLR:  next_state = ST_LOAD;
        ST_LOAD: next_state = ST_WAIT;
        ST_WAIT: if (wait_zero) next_state = ST_ACCU;
        ST_ACCU: next_state = (btch_zero || addr_last) ? ST_UPD : ST_LOAD;
        ST_UPD:  next_state = (addr_in_range || !epoch_last) ? ST_CLR : ST_DONE;
        ST_DONE: next_state = ST_IDLE;
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so they align with the state.
  always_comb begin
    pulse_d = pulse_for(next_state);
    busy_d  = (next_state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_smp      <= '0;
      n_epoch    <= '0;
      addr       <= '0;
      epoch      <= '0;
      o_smp_addr <= '0;
      o_cost     <= '0;
    end else if (!i_abort) begin
      case (state)
        ST_IDLE: if (i_start) begin
          n_smp   <= i_n_smp;
          n_epoch <= i_n_epoch;
          addr    <= '0;
          epoch   <= '0;
        end
        ST_ACCU: addr <= addr_nxt;
        ST_UPD: begin
          o_cost <= i_cost;
          if (!addr_in_range) begin
            addr <= '0;
            if (!epoch_last) epoch <= epoch + EP_W'(1);
          end
        end
        default: ;
      endcase
      if (next_state == ST_LOAD) o_smp_addr <= addr_nxt[SMP_AW-1:0];
    end
  end

  assign o_ld       = pulse_q[P_LD];
  assign o_accu     = pulse_q[P_ACCU];
  assign o_rst_btch = pulse_q[P_RST_BTCH];
  assign o_wb_upd   = pulse_q[P_WB_UPD];
  assign o_done     = pulse_q[P_DONE];
  assign o_epoch    = epoch;

endmodule
